// File: rtl/watch_mode_ctrl_pkg.sv
// Shared types and constants for the watch mode scheduler.
// State encoding, one-hot mode codes and display width.
package watch_mode_ctrl_pkg;

  localparam int BCD_W = 16;

  typedef enum logic [1:0] {
    ST_WATCH = 2'd0,
    ST_STOPW = 2'd1,
    ST_TIMER = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [2:0] MODE_WATCH = 3'b001;
  localparam logic [2:0] MODE_STOPW = 3'b010;
  localparam logic [2:0] MODE_TIMER = 3'b100;

  // The alarm is presented to the user as timer mode.
  function automatic logic [2:0] mode_of(state_t s);
    unique case (s)
      ST_WATCH: mode_of = MODE_WATCH;
      ST_STOPW: mode_of = MODE_STOPW;
      default:  mode_of = MODE_TIMER;
    endcase
  endfunction

  // Mode button rotation among the three user modes.
  function automatic state_t next_mode(state_t s);
    unique case (s)
      ST_WATCH: next_mode = ST_STOPW;
      ST_STOPW: next_mode = ST_TIMER;
      default:  next_mode = ST_WATCH;
    endcase
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_router.sv
// Button demux: steers function-button pulses to the active block.
// Purely combinational; the parent registers the three buses.
module mode_btn_router
  import watch_mode_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] btn_pulse,
  input  logic       drop,
  output logic [3:0] watch_btn,
  output logic [3:0] stopw_btn,
  output logic [3:0] timer_btn
);

  // Only one bus carries the pulses; a dropped cycle yields all zeros.
  always_comb begin
    watch_btn = 4'd0;
    stopw_btn = 4'd0;
    timer_btn = 4'd0;
    if (!drop) begin
      unique case (state)
        ST_WATCH: watch_btn = btn_pulse;
        ST_STOPW: stopw_btn = btn_pulse;
        default:  timer_btn = btn_pulse;
      endcase
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode scheduler: owns the button set and the FND for three blocks.
// Optional idle auto-return to watch mode under `IDLE_RETURN_EN.
module watch_mode_ctrl
  import watch_mode_ctrl_pkg::*;
#(
  parameter int IDLE_SEC = 30
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             sec_tick,
  input  logic             btn_mode,
  input  logic [3:0]       btn_pulse,
  input  logic             timer_alarm,
  input  logic [BCD_W-1:0] watch_value,
  input  logic [BCD_W-1:0] stopw_value,
  input  logic [BCD_W-1:0] timer_value,
  output logic [3:0]       watch_btn,
  output logic [3:0]       stopw_btn,
  output logic [3:0]       timer_btn,
  output logic [BCD_W-1:0] disp_value,
  output logic             disp_blank,
  output logic [2:0]       mode
);

  if (IDLE_SEC < 1 || IDLE_SEC > 255) begin : g_bad_idle_sec
    $error("IDLE_SEC must lie in 1..255");
  end

  state_t           state;
  state_t           state_n;
  state_t           saved_mode;
  logic             alarm_q;
  logic             blink;
  logic             blink_n;
  logic             alarm_rise;
  logic             drop;
  logic             idle_hit;
  logic [3:0]       w_btn;
  logic [3:0]       s_btn;
  logic [3:0]       t_btn;
  logic [BCD_W-1:0] disp_sel;

  assign alarm_rise = timer_alarm & ~alarm_q & (state != ST_ALARM);
  assign drop       = btn_mode | alarm_rise;

`ifdef IDLE_RETURN_EN
  logic [7:0] idle_cnt;
  logic       idle_busy;

  assign idle_hit  = (idle_cnt == 8'(IDLE_SEC));
  assign idle_busy = (state == ST_STOPW) | (state == ST_TIMER);

  // Count quiet seconds in stopwatch/timer; any activity restarts it.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      idle_cnt <= 8'd0;
    end else if (!idle_busy || state_n != state ||
                 |btn_pulse || btn_mode) begin
      idle_cnt <= 8'd0;
    end else if (sec_tick) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  // Next state: alarm entry beats idle return, which beats btn_mode.
  always_comb begin
    state_n = state;
    if (state == ST_ALARM) begin
      if (!timer_alarm) state_n = saved_mode;
    end else if (alarm_rise) begin
      state_n = ST_ALARM;
    end else if (idle_hit) begin
      state_n = ST_WATCH;
    end else if (btn_mode) begin
      state_n = next_mode(state);
    end
  end

  // Display source follows the state that was active this cycle.
  always_comb begin
    unique case (state)
      ST_WATCH: disp_sel = watch_value;
      ST_STOPW: disp_sel = stopw_value;
      default:  disp_sel = timer_value;
    endcase
  end

  // Blink runs only while the alarm is shown and restarts dark.
  assign blink_n = (state == ST_ALARM) ? (blink ^ sec_tick) : 1'b0;

  mode_btn_router u_router (
    .state     (state),
    .btn_pulse (btn_pulse),
    .drop      (drop),
    .watch_btn (w_btn),
    .stopw_btn (s_btn),
    .timer_btn (t_btn)
  );

  // State, pre-empted mode and all registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= ST_WATCH;
      saved_mode <= ST_WATCH;
      alarm_q    <= 1'b0;
      blink      <= 1'b0;
      watch_btn  <= 4'd0;
      stopw_btn  <= 4'd0;
      timer_btn  <= 4'd0;
      disp_value <= '0;
      disp_blank <= 1'b0;
      mode       <= MODE_WATCH;
    end else begin
      state      <= state_n;
      alarm_q    <= timer_alarm;
      if (alarm_rise) saved_mode <= state;
      blink      <= blink_n;
      watch_btn  <= w_btn;
      stopw_btn  <= s_btn;
      timer_btn  <= t_btn;
      disp_value <= disp_sel;
      disp_blank <= blink_n;
      mode       <= mode_of(state_n);
    end
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed plan plus random traffic,
// every cycle checked against an index-based mode model.
module tb_watch_mode_ctrl;

  localparam int IDLE = 3;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        sec_tick;
  logic        btn_mode;
  logic [3:0]  btn_pulse;
  logic        timer_alarm;
  logic [15:0] watch_value;
  logic [15:0] stopw_value;
  logic [15:0] timer_value;
  logic [3:0]  watch_btn;
  logic [3:0]  stopw_btn;
  logic [3:0]  timer_btn;
  logic [15:0] disp_value;
  logic        disp_blank;
  logic [2:0]  mode;

  int n_vec = 0;
  int n_err = 0;

  int cur   = 0;
  bit alarm = 0;
  bit alq   = 0;
  bit blink = 0;
  int idle  = 0;

  logic [3:0]  exp_w, exp_s, exp_t;
  logic [15:0] exp_disp;
  logic        exp_blank;
  logic [2:0]  exp_mode;

  watch_mode_ctrl #(.IDLE_SEC(IDLE)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .sec_tick    (sec_tick),
    .btn_mode    (btn_mode),
    .btn_pulse   (btn_pulse),
    .timer_alarm (timer_alarm),
    .watch_value (watch_value),
    .stopw_value (stopw_value),
    .timer_value (timer_value),
    .watch_btn   (watch_btn),
    .stopw_btn   (stopw_btn),
    .timer_btn   (timer_btn),
    .disp_value  (disp_value),
    .disp_blank  (disp_blank),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mode index 0/1/2 plus an alarm flag; cur is kept as the
  // pre-empted mode while the alarm is shown.
  task automatic model_step();
    int act;
    int prev_cur;
    bit prev_alarm;
    bit rise;
    bit drp;
    act  = alarm ? 2 : cur;
    rise = !alarm && timer_alarm && !alq;
    drp  = btn_mode || rise;
    exp_w = (!drp && act == 0) ? btn_pulse : 4'd0;
    exp_s = (!drp && act == 1) ? btn_pulse : 4'd0;
    exp_t = (!drp && act == 2) ? btn_pulse : 4'd0;
    exp_disp = (act == 0) ? watch_value :
               (act == 1) ? stopw_value : timer_value;
    blink = alarm ? (blink ^ sec_tick) : 1'b0;
    exp_blank = blink;
    prev_cur = cur;
    prev_alarm = alarm;
    if (alarm) begin
      if (!timer_alarm) alarm = 0;
    end else if (rise) begin
      alarm = 1;
    end
`ifdef IDLE_RETURN_EN
    else if (idle == IDLE) begin
      cur = 0;
    end
`endif
    else if (btn_mode) begin
      cur = (cur + 1) % 3;
    end
`ifdef IDLE_RETURN_EN
    if (alarm || prev_alarm || cur == 0 || cur != prev_cur ||
        btn_pulse != 0 || btn_mode)
      idle = 0;
    else
      idle = idle + int'(sec_tick);
`endif
    alq = timer_alarm;
    exp_mode = alarm ? 3'b100 : 3'(1 << cur);
  endtask

  task automatic step(bit m, logic [3:0] p, bit t, bit a);
    @(negedge clk);
    btn_mode    = m;
    btn_pulse   = p;
    sec_tick    = t;
    timer_alarm = a;
    watch_value = 16'($urandom);
    stopw_value = 16'($urandom);
    timer_value = 16'($urandom);
    model_step();
    @(posedge clk);
    #1;
    check("mode",       {13'd0, mode},       {13'd0, exp_mode});
    check("watch_btn",  {12'd0, watch_btn},  {12'd0, exp_w});
    check("stopw_btn",  {12'd0, stopw_btn},  {12'd0, exp_s});
    check("timer_btn",  {12'd0, timer_btn},  {12'd0, exp_t});
    check("disp_value", disp_value,          exp_disp);
    check("disp_blank", {15'd0, disp_blank}, {15'd0, exp_blank});
  endtask

  initial begin
    bit a;
    reset_p     = 1'b1;
    sec_tick    = 1'b0;
    btn_mode    = 1'b0;
    btn_pulse   = 4'd0;
    timer_alarm = 1'b0;
    watch_value = 16'h1234;
    stopw_value = 16'h5678;
    timer_value = 16'h9abc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mode",  {13'd0, mode}, 16'h0001);
    check("rst_disp",  disp_value, 16'h0000);
    check("rst_blank", {15'd0, disp_blank}, 16'h0000);
    check("rst_btn",   {4'd0, watch_btn, stopw_btn, timer_btn}, 16'h0000);
    @(negedge clk);
    reset_p = 1'b0;

    // mode rotation, display following one clk later
    repeat (3) begin
      step(1, 4'd0, 0, 0);
      step(0, 4'd0, 0, 0);
    end

    // stopwatch button routing
    step(1, 4'd0, 0, 0);
    step(0, 4'b0001, 0, 0);
    step(0, 4'd0, 0, 0);

    // alarm pre-empts stopwatch, blink, ack, clear
    step(0, 4'd0, 0, 1);
    repeat (4) begin
      step(0, 4'd0, 1, 1);
      step(0, 4'd0, 0, 1);
    end
    step(0, 4'b1000, 0, 1);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 1, 0);

    // back to watch, then mode and alarm edge together
    step(1, 4'd0, 0, 0);
    step(1, 4'd0, 0, 0);
    step(1, 4'd0, 0, 1);
    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);

    // mode pulse drops a coincident function pulse
    step(1, 4'b0010, 0, 0);
    step(0, 4'd0, 0, 0);

    // alarm rising while already in timer mode
    step(1, 4'd0, 0, 0);
    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);

`ifdef IDLE_RETURN_EN
    // idle return from timer, restarted by a button
    step(0, 4'd0, 1, 0);
    step(0, 4'd0, 1, 0);
    step(0, 4'b0001, 0, 0);
    repeat (3) step(0, 4'd0, 1, 0);
    repeat (2) step(0, 4'd0, 0, 0);
`endif

    a = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) a = ~a;
      step($urandom_range(0, 5) == 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
           $urandom_range(0, 3) == 0,
           a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
